// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser_if
//  Description : Byte-strobe input and parsed-frame output bundle for
//                uart_frame_parser.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        frame_valid;
  logic [7:0]  frame_addr;
  logic [3:0]  frame_len;
  logic [63:0] frame_data;
  logic        frame_err;
  logic [1:0]  err_code;

  // Byte source / frame consumer side
  modport master (
    output rx_done, rx_data,
    input  frame_valid, frame_addr, frame_len, frame_data, frame_err, err_code
  );

  // Parser side
  modport slave (
    input  rx_done, rx_data,
    output frame_valid, frame_addr, frame_len, frame_data, frame_err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Parses SYNC/ADDR/LEN/PAYLOAD/CHK frames from a byte strobe
//                stream, checks the XOR checksum, and reports good frames or
//                aborts (checksum, bad length, inter-byte timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input wire logic           clk,
  input wire logic           rst,
  uart_frame_parser_if.slave io_frm
);

  localparam int               c_TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0]  c_TMAX  = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       c_MAXL  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_TW-1:0] r_timer;
  logic [7:0]      r_chk;
  logic [7:0]      r_addr;
  logic [3:0]      r_len;
  logic [3:0]      r_idx;
  logic [63:0]     r_pay;

  logic            r_frame_valid;
  logic            r_frame_err;
  logic [1:0]      r_err_code;
  logic [7:0]      r_frame_addr;
  logic [3:0]      r_frame_len;
  logic [63:0]     r_frame_data;

  logic            w_timeout;
  logic            w_good;
  logic            w_abort;
  logic [1:0]      w_abort_code;
  logic [63:0]     w_data_masked;

  // Timeout only counts inside a frame and loses to a same-cycle byte
  assign w_timeout = (r_state != S_IDLE) && !io_frm.rx_done && (r_timer == c_TMAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and completion/abort decode
  always_comb begin
    w_state_nxt  = r_state;
    w_good       = 1'b0;
    w_abort      = 1'b0;
    w_abort_code = 2'd0;
    if (w_timeout) begin
      w_state_nxt  = S_IDLE;
      w_abort      = 1'b1;
      w_abort_code = 2'd3;
    end else if (io_frm.rx_done) begin
      case (r_state)
        S_IDLE: begin
          if (io_frm.rx_data == SYNC_BYTE) w_state_nxt = S_ADDR;
        end
        S_ADDR: w_state_nxt = S_LEN;
        S_LEN: begin
          if (io_frm.rx_data == 8'd0) begin
            w_state_nxt = S_CHECK;
          end else if (io_frm.rx_data <= c_MAXL) begin
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_state_nxt  = S_IDLE;
            w_abort      = 1'b1;
            w_abort_code = 2'd2;
          end
        end
        S_PAYLOAD: begin
          if ((r_idx + 4'd1) == r_len) w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          w_state_nxt = S_IDLE;
          if (io_frm.rx_data == r_chk) begin
            w_good = 1'b1;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = 2'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Payload bytes beyond LEN may be stale from an earlier frame; zero them
  always_comb begin
    w_data_masked = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < r_len) w_data_masked[8*k +: 8] = r_pay[8*k +: 8];
    end
  end

  // Inter-byte timer, frame capture and running checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_chk   <= 8'd0;
      r_addr  <= 8'd0;
      r_len   <= 4'd0;
      r_idx   <= 4'd0;
      r_pay   <= 64'd0;
    end else begin
      if ((w_state_nxt == S_IDLE) || io_frm.rx_done) r_timer <= '0;
      else                                           r_timer <= r_timer + 1'b1;

      if (io_frm.rx_done) begin
        case (r_state)
          S_IDLE: begin
            r_chk <= 8'd0;
            r_idx <= 4'd0;
          end
          S_ADDR: begin
            r_addr <= io_frm.rx_data;
            r_chk  <= io_frm.rx_data;
          end
          S_LEN: begin
            r_len <= io_frm.rx_data[3:0];
            r_chk <= r_chk ^ io_frm.rx_data;
            r_idx <= 4'd0;
          end
          S_PAYLOAD: begin
            r_pay[{r_idx[2:0], 3'b000} +: 8] <= io_frm.rx_data;
            r_chk <= r_chk ^ io_frm.rx_data;
            r_idx <= r_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered result pulses and held frame outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= 2'd0;
      r_frame_addr  <= 8'd0;
      r_frame_len   <= 4'd0;
      r_frame_data  <= 64'd0;
    end else begin
      r_frame_valid <= w_good;
      r_frame_err   <= w_abort;
      if (w_abort) r_err_code <= w_abort_code;
      if (w_good) begin
        r_frame_addr <= r_addr;
        r_frame_len  <= r_len;
        r_frame_data <= w_data_masked;
      end
    end
  end

  assign io_frm.frame_valid = r_frame_valid;
  assign io_frm.frame_err   = r_frame_err;
  assign io_frm.err_code    = r_err_code;
  assign io_frm.frame_addr  = r_frame_addr;
  assign io_frm.frame_len   = r_frame_len;
  assign io_frm.frame_data  = r_frame_data;

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum payload bytes per frame (legal range 1..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum clk cycles allowed between consecutive bytes inside a frame.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe: a received byte is valid on rx_data.
REQ-007 SHALL have port rx_data  input  8  received byte, sampled only when rx_done=1.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse: a good frame is on the frame_* outputs.
REQ-009 SHALL have port frame_addr  output  8  address byte of the last good frame.
REQ-010 SHALL have port frame_len  output  4  payload length of the last good frame.
REQ-011 SHALL have port frame_data  output  64  payload of the last good frame; byte k at bits [8k+7:8k].
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: frame was aborted.
REQ-013 SHALL have port err_code  output  2  abort cause: 1 = checksum, 2 = bad length, 3 = timeout; held until the next frame_err.

Function
REQ-014 SHALL accept the frame format SYNC, ADDR, LEN, PAYLOAD[0..LEN-1], CHK, one byte per rx_done strobe.
REQ-015 SHALL use the states IDLE, ADDR, LEN, PAYLOAD and CHECK.
REQ-016 SHALL, in IDLE, go to ADDR on a byte equal to SYNC_BYTE, and silently ignore any other byte.
REQ-017 SHALL, in ADDR, store the byte as the address and go to LEN.
REQ-018 SHALL, in LEN, treat LEN=0 as legal and go directly to CHECK.
REQ-019 SHALL, in LEN, go to PAYLOAD when 1<=LEN<=MAX_LEN.
REQ-020 SHALL, in LEN, when LEN>MAX_LEN, pulse frame_err with err_code=2 and return to IDLE.
REQ-021 SHALL, in PAYLOAD, store each byte at index 0..LEN-1 and go to CHECK after byte LEN-1.
REQ-022 SHALL compute the checksum as the 8-bit XOR of ADDR, LEN and all payload bytes; SYNC is excluded.
REQ-023 SHALL, in CHECK, when CHK equals the checksum: pulse frame_valid, update frame_addr, frame_len and frame_data, and return to IDLE.
REQ-024 SHALL, in CHECK, when CHK does not match: pulse frame_err with err_code=1, leave the frame_* outputs unchanged, and return to IDLE.
REQ-025 SHALL drive frame_valid/frame_err exactly one cycle after the rx_done carrying the final byte, for exactly one cycle.
REQ-026 SHALL set to zero the frame_data bytes at index >= LEN on a good frame.
REQ-027 SHALL hold frame_addr, frame_len and frame_data stable between frame_valid pulses.
REQ-028 SHALL clear the inter-byte timer on every accepted byte and hold it at 0 in IDLE.
REQ-029 SHALL increment the inter-byte timer every cycle without rx_done in any other state.
REQ-030 SHALL, when the timer reaches TIMEOUT_CYCLES-1 with no rx_done that cycle, pulse frame_err with err_code=3 and return to IDLE.
REQ-031 SHALL give rx_done priority over timeout when both occur in the same cycle.
REQ-032 SHALL never assert frame_valid and frame_err in the same cycle.
REQ-033 SHALL handle back-to-back frames, with a SYNC byte arriving on the strobe immediately after CHK, without loss.
REQ-034 SHALL treat a SYNC_BYTE value received inside a frame as ordinary data (no resynchronisation).

Reset
REQ-035 SHALL, while rst=1 on a clock edge, set state=IDLE, timer=0, checksum=0, and all outputs to zero (frame_valid, frame_err, frame_addr, frame_len, frame_data, err_code).
REQ-036 SHALL, on rst asserted mid-frame, discard the partial frame with no frame_valid or frame_err pulse.

Verification
REQ-037 SHALL verify good frame: bytes A5 10 02 01 02 11 -> one frame_valid pulse, frame_addr=8'h10, frame_len=2, frame_data=64'h0000_0000_0000_0201, frame_err=0.
REQ-038 SHALL verify bad checksum: bytes A5 10 02 01 02 12 -> frame_err pulse, err_code=1, frame_* outputs keep their previous values.
REQ-039 SHALL verify bad length and zero length: bytes A5 20 09 -> frame_err with err_code=2; then bytes A5 20 00 20 -> frame_valid with frame_len=0 and frame_data=0.
REQ-040 SHALL verify timeout: bytes A5 10, then no strobe for TIMEOUT_CYCLES cycles -> frame_err with err_code=3; a following good frame is then accepted.
REQ-041 SHALL verify noise and back-to-back: bytes 00 FF A5 01 01 A5 A5 immediately followed by A5 02 00 02 -> frame_valid with addr=01, data byte0=A5; then frame_valid with addr=02, len=0.
REQ-042 SHALL verify reset mid-frame: rst pulsed after bytes A5 10 02 01 -> no pulse on frame_valid or frame_err; the good frame from REQ-037 afterwards is accepted.
